// File: rtl/lieat_biu_rd_arbiter_if.sv
// Bus bundle for the two-master / one-slave AXI-lite read arbiter.
//   m0_*  : I-cache refill read channel (AR + R)
//   m1_*  : LSU / D-cache refill read channel (AR + R)
//   s_*   : DRAM-side read channel
// Modports:
//   slave  : the arbiter's view (it serves m0/m1 and drives the DRAM port)
//   master : the environment's view (requesters plus DRAM model)
interface lieat_biu_rd_arbiter_if #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
);
  logic [AW-1:0] m0_araddr;
  logic          m0_arvalid;
  logic          m0_arready;
  logic [DW-1:0] m0_rdata;
  logic          m0_rvalid;
  logic          m0_rready;

  logic [AW-1:0] m1_araddr;
  logic          m1_arvalid;
  logic          m1_arready;
  logic [DW-1:0] m1_rdata;
  logic          m1_rvalid;
  logic          m1_rready;

  logic [AW-1:0] s_araddr;
  logic          s_arvalid;
  logic          s_arready;
  logic [DW-1:0] s_rdata;
  logic          s_rvalid;
  logic          s_rready;

  modport slave (
    input  m0_araddr, m0_arvalid, m0_rready,
    input  m1_araddr, m1_arvalid, m1_rready,
    input  s_arready, s_rdata, s_rvalid,
    output m0_arready, m0_rdata, m0_rvalid,
    output m1_arready, m1_rdata, m1_rvalid,
    output s_araddr, s_arvalid, s_rready
  );

  modport master (
    output m0_araddr, m0_arvalid, m0_rready,
    output m1_araddr, m1_arvalid, m1_rready,
    output s_arready, s_rdata, s_rvalid,
    input  m0_arready, m0_rdata, m0_rvalid,
    input  m1_arready, m1_rdata, m1_rvalid,
    input  s_araddr, s_arvalid, s_rready
  );
endinterface

// File: rtl/lieat_biu_rd_arbiter.sv
// Two-master, one-slave AXI-lite read arbiter in front of the DRAM port.
// One AR is accepted at a time, forwarded with a registered s_araddr/s_arvalid,
// and the single R beat is steered back to the master that won the grant.
// Ports:
//   clock : only clock
//   reset : synchronous, active-high
//   bus   : lieat_biu_rd_arbiter_if.slave (m0_*, m1_*, s_* channels)
//   busy  : high whenever the FSM is not in IDLE
// Optional feature macro: LIEAT_BIU_RR_EN
//   defined   -> round-robin on ties using a 1-bit last_grant register
//   undefined -> fixed priority, master 1 (LSU) over master 0 (I-cache)
module lieat_biu_rd_arbiter #(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 64
) (
  input  logic                    clock,
  input  logic                    reset,
  lieat_biu_rd_arbiter_if.slave   bus,
  output logic                    busy
);

  typedef enum logic [2:0] {
    IDLE = 3'b001,
    AR   = 3'b010,
    R    = 3'b100
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic          owner;
  logic          owner_nxt;
  logic [AW-1:0] addr_q;
  logic [AW-1:0] addr_nxt;
  logic [DW-1:0] rdata_fwd;
  logic          rst_q;
  logic          pick1;
  logic          gnt0;
  logic          gnt1;
  logic          s_rready_c;

`ifdef LIEAT_BIU_RR_EN
  logic          last_grant;

  // On a tie the master that did not win last time goes first.
  always_comb pick1 = bus.m1_arvalid & (~bus.m0_arvalid | ~last_grant);
`else
  always_comb pick1 = bus.m1_arvalid;
`endif

  assign rdata_fwd = bus.s_rdata;

  always_comb begin
    state_nxt       = state;
    owner_nxt       = owner;
    addr_nxt        = addr_q;
    gnt0            = 1'b0;
    gnt1            = 1'b0;
    s_rready_c      = 1'b0;
    bus.m0_rvalid   = 1'b0;
    bus.m1_rvalid   = 1'b0;
    bus.m0_rdata    = '0;
    bus.m1_rdata    = '0;

    unique case (state)
      IDLE: begin
        // Beats arriving here are strays left over from a reset; sink them.
        s_rready_c = 1'b1;
        // rst_q keeps grants off during the first cycle after reset.
        if (!rst_q && (bus.m0_arvalid || bus.m1_arvalid)) begin
          gnt1      = pick1;
          gnt0      = ~pick1;
          owner_nxt = pick1;
          addr_nxt  = pick1 ? bus.m1_araddr : bus.m0_araddr;
          state_nxt = AR;
        end
      end
      AR: begin
        if (bus.s_arready) state_nxt = R;
      end
      R: begin
        if (owner) begin
          bus.m1_rvalid = bus.s_rvalid;
          bus.m1_rdata  = rdata_fwd;
          s_rready_c    = bus.m1_rready;
        end else begin
          bus.m0_rvalid = bus.s_rvalid;
          bus.m0_rdata  = rdata_fwd;
          s_rready_c    = bus.m0_rready;
        end
        if (bus.s_rvalid && s_rready_c) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase

    bus.m0_arready = gnt0;
    bus.m1_arready = gnt1;
    bus.s_rready   = s_rready_c;

    // Combinational outputs are held quiet while reset is asserted.
    if (reset) begin
      bus.m0_arready = 1'b0;
      bus.m1_arready = 1'b0;
      bus.m0_rvalid  = 1'b0;
      bus.m1_rvalid  = 1'b0;
      bus.m0_rdata   = '0;
      bus.m1_rdata   = '0;
      bus.s_rready   = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    rst_q <= reset;
    if (reset) begin
      state  <= IDLE;
      owner  <= 1'b0;
      addr_q <= '0;
`ifdef LIEAT_BIU_RR_EN
      last_grant <= 1'b0;
`endif
    end else begin
      state  <= state_nxt;
      owner  <= owner_nxt;
      addr_q <= addr_nxt;
`ifdef LIEAT_BIU_RR_EN
      if (gnt0 || gnt1) last_grant <= gnt1;
`endif
    end
  end

  assign bus.s_araddr  = addr_q;
  assign bus.s_arvalid = (state == AR);
  assign busy          = (state != IDLE) && !reset;

endmodule

// File: tb/tb_lieat_biu_rd_arbiter.sv
`timescale 1ns/1ps
module tb_lieat_biu_rd_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 64;
`ifdef LIEAT_BIU_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset;
  logic busy;

  always #5 clock = ~clock;

  lieat_biu_rd_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  lieat_biu_rd_arbiter #(.AW(AW), .DW(DW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus),
    .busy  (busy)
  );

  int total = 0;
  int bad   = 0;
  int tmo, leak, overlap;
  bit stop;
  bit model_last;
  int unsigned ar_stall_max, r_delay_max;
  bit rr_rand;

  logic [AW-1:0] addr0[$], addr1[$];
  int            grant_q[$], beat_m[$], exp_m[$];
  logic [AW-1:0] ar_q[$], exp_a[$];
  logic [DW-1:0] beat_d[$], sent[$];

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got running want finished");
    $fatal(1);
  end

  // ---------------- bus-functional helpers (drive/collect only) ----------------
  task automatic master_bfm(input int m, input int n);
    for (int i = 0; i < n; i++) begin
      bit g;
      int w;
      if (m == 0) begin bus.m0_arvalid = 1'b1; bus.m0_araddr = addr0[i]; end
      else        begin bus.m1_arvalid = 1'b1; bus.m1_araddr = addr1[i]; end
      g = 1'b0; w = 0;
      while (!g && w < 400) begin
        @(negedge clock);
        g = (m == 0) ? bus.m0_arready : bus.m1_arready;
        @(posedge clock); #1;
        w++;
      end
      if (!g) begin tmo++; break; end
    end
    if (m == 0) bus.m0_arvalid = 1'b0; else bus.m1_arvalid = 1'b0;
  endtask

  task automatic slave_bfm(input int n);
    for (int i = 0; i < n; i++) begin
      int w;
      bit hs;
      w = 0;
      while (!bus.s_arvalid && w < 400) begin @(posedge clock); #1; w++; end
      if (w >= 400) begin tmo++; break; end
      repeat ($urandom_range(0, ar_stall_max)) begin @(posedge clock); #1; end
      bus.s_arready = 1'b1;
      @(posedge clock); #1;
      bus.s_arready = 1'b0;
      repeat ($urandom_range(0, r_delay_max)) begin @(posedge clock); #1; end
      bus.s_rvalid = 1'b1;
      bus.s_rdata  = {$urandom, $urandom};
      sent.push_back(bus.s_rdata);
      hs = 1'b0; w = 0;
      while (!hs && w < 400) begin
        @(negedge clock);
        hs = bus.s_rready;
        @(posedge clock); #1;
        w++;
      end
      bus.s_rvalid = 1'b0;
      if (!hs) begin tmo++; break; end
    end
  endtask

  task automatic rready_drv;
    while (!stop) begin
      bus.m0_rready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      bus.m1_rready = rr_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clock); #1;
    end
    bus.m0_rready = 1'b1;
    bus.m1_rready = 1'b1;
  endtask

  task automatic monitor;
    bit [1:0] outst;
    outst = 2'b00;
    while (!stop) begin
      @(negedge clock);
      if (bus.m0_arvalid && bus.m0_arready) begin
        if (outst != 2'b00) overlap++;
        outst[0] = 1'b1; grant_q.push_back(0);
      end
      if (bus.m1_arvalid && bus.m1_arready) begin
        if (outst != 2'b00) overlap++;
        outst[1] = 1'b1; grant_q.push_back(1);
      end
      if (bus.s_arvalid && bus.s_arready) ar_q.push_back(bus.s_araddr);
      if (bus.m0_rvalid && bus.m1_rvalid) leak++;
      if (bus.m0_rvalid && !outst[0]) leak++;
      if (bus.m1_rvalid && !outst[1]) leak++;
      if (!outst[0] && bus.m0_rdata != '0) leak++;
      if (!outst[1] && bus.m1_rdata != '0) leak++;
      if (bus.m0_rvalid && bus.m0_rready) begin
        beat_m.push_back(0); beat_d.push_back(bus.m0_rdata); outst[0] = 1'b0;
      end
      if (bus.m1_rvalid && bus.m1_rready) begin
        beat_m.push_back(1); beat_d.push_back(bus.m1_rdata); outst[1] = 1'b0;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b1;
    bus.m0_arvalid = 1'b0; bus.m0_araddr = '0; bus.m0_rready = 1'b1;
    bus.m1_arvalid = 1'b1; bus.m1_araddr = 32'h0000_0300; bus.m1_rready = 1'b1;
    bus.s_arready = 1'b0; bus.s_rvalid = 1'b0; bus.s_rdata = '0;
    repeat (3) @(posedge clock);
    #1;
    @(negedge clock);
    total++; if (bus.m1_arready !== 1'b0) begin bad++; $display("FAIL rst_arready: got %b want 0", bus.m1_arready); end
    total++; if (bus.s_rready !== 1'b1) begin bad++; $display("FAIL rst_s_rready: got %b want 1", bus.s_rready); end
    total++; if (busy !== 1'b0 || bus.s_arvalid !== 1'b0) begin bad++; $display("FAIL rst_busy_arvalid: got %b%b want 00", busy, bus.s_arvalid); end
    total++; if (bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0) begin bad++; $display("FAIL rst_rvalid: got %b%b want 00", bus.m0_rvalid, bus.m1_rvalid); end
    @(posedge clock); #1; reset = 1'b0;
    @(negedge clock);
    total++; if (bus.m1_arready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL post_rst_quiet: got arready=%b busy=%b want 0 0", bus.m1_arready, busy); end
    @(posedge clock); #1;
    @(negedge clock);
    total++; if (bus.m1_arready !== 1'b1) begin bad++; $display("FAIL post_rst_grant: got %b want 1", bus.m1_arready); end
    @(posedge clock); #1; bus.m1_arvalid = 1'b0; bus.s_arready = 1'b1;
    @(negedge clock);
    total++; if (bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h0000_0300) begin bad++; $display("FAIL rst_first_ar: got %b %h want 1 00000300", bus.s_arvalid, bus.s_araddr); end
    @(posedge clock); #1; bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 64'hA5A5_0000_FFFF_1234;
    @(negedge clock);
    total++; if (bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 64'hA5A5_0000_FFFF_1234) begin bad++; $display("FAIL rst_first_r: got %b %h want 1 a5a50000ffff1234", bus.m1_rvalid, bus.m1_rdata); end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_single;
    int bc;
    bc = 0;
    bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h8000_0010; bus.s_arready = 1'b1;
    @(negedge clock); bc += int'(busy);
    total++; if (bus.m0_arready !== 1'b1 || bus.m1_arready !== 1'b0) begin bad++; $display("FAIL single_grant: got %b%b want 10", bus.m0_arready, bus.m1_arready); end
    @(posedge clock); #1; bus.m0_arvalid = 1'b0;
    @(negedge clock); bc += int'(busy);
    total++; if (bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h8000_0010) begin bad++; $display("FAIL single_ar: got %b %h want 1 80000010", bus.s_arvalid, bus.s_araddr); end
    @(posedge clock); #1; bus.s_arready = 1'b0;
    @(negedge clock); bc += int'(busy);
    total++; if (bus.m0_rvalid !== 1'b0 || bus.s_arvalid !== 1'b0) begin bad++; $display("FAIL single_wait: got rvalid=%b arvalid=%b want 0 0", bus.m0_rvalid, bus.s_arvalid); end
    @(posedge clock); #1; bus.s_rvalid = 1'b1; bus.s_rdata = 64'h1122_3344_5566_7788;
    @(negedge clock); bc += int'(busy);
    total++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 64'h1122_3344_5566_7788) begin bad++; $display("FAIL single_data: got %b %h want 1 1122334455667788", bus.m0_rvalid, bus.m0_rdata); end
    total++; if (bus.m1_rvalid !== 1'b0 || bus.m1_rdata !== '0) begin bad++; $display("FAIL single_nonowner: got %b %h want 0 0", bus.m1_rvalid, bus.m1_rdata); end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    @(negedge clock); bc += int'(busy);
    total++; if (bc !== 3) begin bad++; $display("FAIL single_busy_cycles: got %0d want 3", bc); end
    @(posedge clock); #1;
    model_last = 1'b0;
  endtask

  task automatic test_arbitration(input string name, input int n0, input int n1,
                                  input int unsigned stall_max, input bit rand_rr);
    int r0, r1, i0, i1, w;
    grant_q.delete(); ar_q.delete(); beat_m.delete(); beat_d.delete(); sent.delete();
    tmo = 0; leak = 0; overlap = 0; stop = 1'b0;
    ar_stall_max = stall_max; r_delay_max = stall_max; rr_rand = rand_rr;
    fork
      begin
        fork
          master_bfm(0, n0);
          master_bfm(1, n1);
          slave_bfm(n0 + n1);
        join
        stop = 1'b1;
      end
      monitor();
      rready_drv();
    join
    // Reference: both requesters keep asking, so every grant with work left on
    // both sides is a tie; ties go to master 1 or to the master that lost last.
    exp_m.delete(); exp_a.delete();
    r0 = n0; r1 = n1; i0 = 0; i1 = 0;
    while (r0 + r1 > 0) begin
      if (r0 > 0 && r1 > 0) w = RR ? int'(!model_last) : 1;
      else                  w = (r1 > 0) ? 1 : 0;
      exp_m.push_back(w);
      if (w == 1) begin exp_a.push_back(addr1[i1]); i1++; r1--; end
      else        begin exp_a.push_back(addr0[i0]); i0++; r0--; end
      model_last = w[0];
    end
    total++; if (tmo !== 0) begin bad++; $display("FAIL %s_timeout: got %0d want 0", name, tmo); end
    total++; if (overlap !== 0) begin bad++; $display("FAIL %s_overlap: got %0d want 0", name, overlap); end
    total++; if (leak !== 0) begin bad++; $display("FAIL %s_leak: got %0d want 0", name, leak); end
    total++; if (grant_q.size() !== exp_m.size() || beat_m.size() !== exp_m.size()) begin
      bad++; $display("FAIL %s_count: got grants=%0d beats=%0d want %0d", name, grant_q.size(), beat_m.size(), exp_m.size());
    end
    for (int i = 0; i < exp_m.size(); i++) begin
      if (i < grant_q.size()) begin
        total++; if (grant_q[i] !== exp_m[i]) begin bad++; $display("FAIL %s_grant[%0d]: got m%0d want m%0d", name, i, grant_q[i], exp_m[i]); end
      end
      if (i < ar_q.size()) begin
        total++; if (ar_q[i] !== exp_a[i]) begin bad++; $display("FAIL %s_araddr[%0d]: got %h want %h", name, i, ar_q[i], exp_a[i]); end
      end
      if (i < beat_m.size() && i < sent.size()) begin
        total++; if (beat_m[i] !== exp_m[i] || beat_d[i] !== sent[i]) begin
          bad++; $display("FAIL %s_beat[%0d]: got m%0d %h want m%0d %h", name, i, beat_m[i], beat_d[i], exp_m[i], sent[i]);
        end
      end
    end
  endtask

  task automatic test_tie;
    addr0 = '{32'h0000_0100}; addr1 = '{32'h0000_0200};
    test_arbitration("tie", 1, 1, 0, 1'b0);
  endtask

  task automatic test_back_to_back;
    addr0 = '{32'h0000_0100, 32'h0000_0104}; addr1 = '{32'h0000_0200, 32'h0000_0204};
    test_arbitration("b2b", 2, 2, 0, 1'b0);
  endtask

  task automatic test_ar_stall;
    bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h0000_0A40;
    @(negedge clock);
    total++; if (bus.m0_arready !== 1'b1) begin bad++; $display("FAIL stall_grant: got %b want 1", bus.m0_arready); end
    @(posedge clock); #1; bus.m0_arvalid = 1'b0; bus.m1_arvalid = 1'b1; bus.m1_araddr = 32'h0000_0B80;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      total++; if (bus.s_arvalid !== 1'b1 || bus.s_araddr !== 32'h0000_0A40 || bus.m0_arready !== 1'b0 || bus.m1_arready !== 1'b0) begin
        bad++; $display("FAIL stall_hold[%0d]: got arvalid=%b addr=%h arready=%b%b want 1 00000a40 00", i, bus.s_arvalid, bus.s_araddr, bus.m0_arready, bus.m1_arready);
      end
      @(posedge clock); #1;
    end
    bus.s_arready = 1'b1;
    @(posedge clock); #1; bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 64'h0BAD_F00D_0000_0001;
    @(negedge clock);
    total++; if (bus.m0_rvalid !== 1'b1 || bus.m1_arready !== 1'b0) begin bad++; $display("FAIL stall_r: got rvalid=%b m1_arready=%b want 1 0", bus.m0_rvalid, bus.m1_arready); end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    @(negedge clock);
    total++; if (bus.m1_arready !== 1'b1) begin bad++; $display("FAIL stall_next_grant: got %b want 1", bus.m1_arready); end
    @(posedge clock); #1; bus.m1_arvalid = 1'b0; bus.s_arready = 1'b1;
    @(posedge clock); #1; bus.s_arready = 1'b0; bus.s_rvalid = 1'b1;
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    model_last = 1'b1;
  endtask

  task automatic test_r_stall;
    bus.m1_arvalid = 1'b1; bus.m1_araddr = 32'h0000_0440; bus.s_arready = 1'b1;
    @(posedge clock); #1; bus.m1_arvalid = 1'b0;
    @(posedge clock); #1; bus.s_arready = 1'b0; bus.s_rvalid = 1'b1;
    bus.s_rdata = 64'hCAFE_0000_BEEF_5555; bus.m1_rready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++; if (bus.s_rready !== 1'b0 || bus.m1_rvalid !== 1'b1 || bus.m1_rdata !== 64'hCAFE_0000_BEEF_5555 || busy !== 1'b1) begin
        bad++; $display("FAIL rstall_hold[%0d]: got s_rready=%b rvalid=%b data=%h busy=%b want 0 1 cafe0000beef5555 1", i, bus.s_rready, bus.m1_rvalid, bus.m1_rdata, busy);
      end
      @(posedge clock); #1;
    end
    bus.m1_rready = 1'b1;
    @(negedge clock);
    total++; if (bus.s_rready !== 1'b1) begin bad++; $display("FAIL rstall_release: got %b want 1", bus.s_rready); end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    @(negedge clock);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rstall_done: got busy=%b want 0", busy); end
    @(posedge clock); #1;
    model_last = 1'b1;
  endtask

  task automatic test_reset_mid;
    bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h0000_0C00; bus.s_arready = 1'b1;
    @(posedge clock); #1; bus.m0_arvalid = 1'b0;
    @(posedge clock); #1; bus.s_arready = 1'b0; reset = 1'b1;   // FSM is in R here
    @(negedge clock);
    total++; if (bus.m0_rvalid !== 1'b0 || bus.s_rready !== 1'b1 || bus.m0_arready !== 1'b0) begin
      bad++; $display("FAIL rmid_in_reset: got rvalid=%b s_rready=%b arready=%b want 0 1 0", bus.m0_rvalid, bus.s_rready, bus.m0_arready);
    end
    @(posedge clock); #1; reset = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
    bus.m0_arvalid = 1'b1; bus.m0_araddr = 32'h0000_0D00;
    @(negedge clock);
    total++; if (bus.s_rready !== 1'b1 || bus.m0_rvalid !== 1'b0 || bus.m1_rvalid !== 1'b0 || busy !== 1'b0 || bus.s_arvalid !== 1'b0) begin
      bad++; $display("FAIL rmid_stray: got s_rready=%b rvalid=%b%b busy=%b arvalid=%b want 1 00 0 0", bus.s_rready, bus.m0_rvalid, bus.m1_rvalid, busy, bus.s_arvalid);
    end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    @(negedge clock);
    total++; if (bus.m0_arready !== 1'b1) begin bad++; $display("FAIL rmid_regrant: got %b want 1", bus.m0_arready); end
    @(posedge clock); #1; bus.m0_arvalid = 1'b0; bus.s_arready = 1'b1;
    @(negedge clock);
    total++; if (bus.s_araddr !== 32'h0000_0D00) begin bad++; $display("FAIL rmid_addr: got %h want 00000d00", bus.s_araddr); end
    @(posedge clock); #1; bus.s_arready = 1'b0; bus.s_rvalid = 1'b1; bus.s_rdata = 64'h0123_4567_89AB_CDEF;
    @(negedge clock);
    total++; if (bus.m0_rvalid !== 1'b1 || bus.m0_rdata !== 64'h0123_4567_89AB_CDEF) begin bad++; $display("FAIL rmid_data: got %b %h want 1 0123456789abcdef", bus.m0_rvalid, bus.m0_rdata); end
    @(posedge clock); #1; bus.s_rvalid = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_random;
    for (int r = 0; r < 8; r++) begin
      int n0, n1;
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if (n0 + n1 == 0) n0 = 1;
      addr0.delete(); addr1.delete();
      for (int i = 0; i < n0; i++) addr0.push_back({$urandom} & 32'hFFFF_FFF8);
      for (int i = 0; i < n1; i++) addr1.push_back({$urandom} & 32'hFFFF_FFF8);
      test_arbitration("rand", n0, n1, 3, 1'b1);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_back_to_back();
    test_ar_stall();
    test_r_stall();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
